// File: rtl/phy_frame_reader_pkg.sv
// Shared definitions for the PHY frame reader: channel count, header layout, FSM states.
package phy_pkg;

  localparam int unsigned NUM_VCHN        = 4;
  localparam logic [3:0]  HDR_TAG_DEFAULT = 4'hA;

  localparam int unsigned HDR_TAG_LSB  = 28;
  localparam int unsigned HDR_TAG_W    = 4;
  localparam int unsigned HDR_VCHN_LSB = 26;
  localparam int unsigned HDR_VCHN_W   = 2;
  localparam int unsigned HDR_SEQ_LSB  = 16;
  localparam int unsigned HDR_SEQ_W    = 8;
  localparam int unsigned HDR_CNT_LSB  = 0;
  localparam int unsigned HDR_CNT_W    = 8;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    NEXT,
    DRAIN
  } state_e;

  function automatic logic [31:0] make_hdr(input logic [3:0] tag, input logic [1:0] vchn,
                                           input logic [7:0] seq, input logic [7:0] cnt);
    logic [31:0] w;
    w = '0;
    w[HDR_TAG_LSB  +: HDR_TAG_W]  = tag;
    w[HDR_VCHN_LSB +: HDR_VCHN_W] = vchn;
    w[HDR_SEQ_LSB  +: HDR_SEQ_W]  = seq;
    w[HDR_CNT_LSB  +: HDR_CNT_W]  = cnt;
    return w;
  endfunction

endpackage

// File: rtl/phy_frame_reader_fifo.sv
// Synchronous show-ahead FIFO with occupancy count; DEPTH must be a power of two.
module out_fifo_sync #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [AW:0]      used_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      used_q;
  logic             push_ok, pop_ok;

  assign empty_o = (used_q == '0);
  assign full_o  = (used_q == (AW+1)'(DEPTH));
  assign used_o  = used_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      used_q   <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   used_q <= used_q + 1'b1;
        2'b01:   used_q <= used_q - 1'b1;
        default: used_q <= used_q;
      endcase
    end
  end

endmodule

// File: rtl/phy_frame_reader.sv
// Reads a completed capture frame channel by channel and emits it as a header+data packet stream.
module phy_frame_reader
  import phy_pkg::*;
#(
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [3:0]  HDR_TAG    = HDR_TAG_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_frame_ready,
  input  logic [15:0] i_out_size,
  output logic [1:0]  o_rd_vchn,
  output logic [7:0]  o_rd_addr,
  input  logic [7:0]  i_data_count,
  input  logic [31:0] i_rd_data,
  output logic [31:0] o_data,
  output logic        o_vld,
  input  logic        i_rdy,
  output logic        o_sop,
  output logic        o_eop,
  output logic        o_busy,
  output logic        o_overrun,
  output logic [7:0]  o_ovr_cnt,
  output logic        o_len_err
);

  localparam int unsigned UW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned FW = 34;

  state_e            state_q, state_d;
  logic [1:0]        vchn_q, vchn_d;
  logic [7:0]        addr_q, addr_d, cnt_q, cnt_d, seq_q, seq_d;
  logic [15:0]       exp_len_q, exp_len_d, emit_q, emit_d;
  logic              served_q, served_d, first_q, first_d, fr_q;
  logic              ovr_q;
  logic [7:0]        ovr_cnt_q;
  logic [RD_LAT-1:0] pvld_q, pvld_d, peop_q, peop_d;

  logic              fifo_empty, fifo_full, push, pop;
  logic [UW-1:0]     fifo_used, inflight;
  logic [UW:0]       occupancy;
  logic [FW-1:0]     fifo_wdata, fifo_rdata;
  logic              hdr_push, issue, last_rd, start, ovr_rise, last_vchn;

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < RD_LAT; i++) inflight = inflight + UW'(pvld_q[i]);
  end

  assign occupancy = {1'b0, fifo_used} + {1'b0, inflight};
  assign last_vchn = (vchn_q == 2'(NUM_VCHN - 1));

  always_comb begin
    state_d   = state_q;
    vchn_d    = vchn_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    seq_d     = seq_q;
    exp_len_d = exp_len_q;
    first_d   = first_q;
    hdr_push  = 1'b0;
    issue     = 1'b0;
    last_rd   = 1'b0;
    start     = 1'b0;
    unique case (state_q)
      IDLE: if (i_frame_ready && !served_q) begin
        start     = 1'b1;
        exp_len_d = i_out_size;
        vchn_d    = '0;
        first_d   = 1'b1;
        state_d   = HDR;
      end
      // Waiting for zero in-flight reads keeps the previous channel's data ahead of this header.
      HDR: if (inflight == '0 && !fifo_full) begin
        hdr_push = 1'b1;
        first_d  = 1'b0;
        cnt_d    = i_data_count;
        addr_d   = '0;
        state_d  = (i_data_count != '0) ? DATA : NEXT;
      end
      DATA: if (occupancy < (UW+1)'(FIFO_DEPTH)) begin
        issue  = 1'b1;
        addr_d = addr_q + 8'd1;
        if (addr_q == cnt_q - 8'd1) begin
          last_rd = 1'b1;
          state_d = NEXT;
        end
      end
      NEXT: begin
        if (last_vchn) begin
          state_d = DRAIN;
        end else begin
          vchn_d  = vchn_q + 2'd1;
          state_d = HDR;
        end
      end
      DRAIN: if (inflight == '0 && fifo_empty) begin
        seq_d   = seq_q + 8'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pvld_d    = pvld_q;
    peop_d    = peop_q;
    pvld_d[0] = issue;
    peop_d[0] = last_rd & last_vchn;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      pvld_d[i] = pvld_q[i-1];
      peop_d[i] = peop_q[i-1];
    end
  end

  assign push       = hdr_push | pvld_q[RD_LAT-1];
  assign fifo_wdata = hdr_push
                    ? {first_q, last_vchn && (i_data_count == '0),
                       make_hdr(HDR_TAG, vchn_q, seq_q, i_data_count)}
                    : {1'b0, peop_q[RD_LAT-1], i_rd_data};

  out_fifo_sync #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (fifo_wdata),
    .pop_i   (pop),
    .data_o  (fifo_rdata),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .used_o  (fifo_used)
  );

  assign o_vld     = ~fifo_empty;
  assign o_data    = o_vld ? fifo_rdata[31:0] : '0;
  assign o_eop     = o_vld & fifo_rdata[32];
  assign o_sop     = o_vld & fifo_rdata[33];
  assign pop       = o_vld & i_rdy;
  assign o_busy    = (state_q != IDLE) | ~fifo_empty;
  assign o_rd_vchn = vchn_q;
  assign o_rd_addr = addr_q;
  assign o_overrun = ovr_q;
  assign o_ovr_cnt = ovr_cnt_q;
  assign o_len_err = pop & o_eop & ((emit_q + 16'd1) != exp_len_q);

  assign ovr_rise = i_frame_ready & ~fr_q & o_busy;
  assign served_d = start | ovr_rise | (served_q & i_frame_ready);
  assign emit_d   = start ? '0 : (pop ? emit_q + 16'd1 : emit_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      vchn_q    <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      seq_q     <= '0;
      exp_len_q <= '0;
      emit_q    <= '0;
      served_q  <= 1'b0;
      first_q   <= 1'b0;
      fr_q      <= 1'b0;
      ovr_q     <= 1'b0;
      ovr_cnt_q <= '0;
      pvld_q    <= '0;
      peop_q    <= '0;
    end else begin
      state_q   <= state_d;
      vchn_q    <= vchn_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      seq_q     <= seq_d;
      exp_len_q <= exp_len_d;
      emit_q    <= emit_d;
      served_q  <= served_d;
      first_q   <= first_d;
      fr_q      <= i_frame_ready;
      ovr_q     <= ovr_rise;
      if (ovr_rise && ovr_cnt_q != 8'hFF) ovr_cnt_q <= ovr_cnt_q + 8'd1;
      pvld_q    <= pvld_d;
      peop_q    <= peop_d;
    end
  end

endmodule

// File: tb/tb_phy_frame_reader.sv
// Directed bench for phy_frame_reader with a capture-buffer model and an expected-word scoreboard.
module tb_phy_frame_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_frame_ready;
  logic [15:0] i_out_size;
  logic [1:0]  o_rd_vchn;
  logic [7:0]  o_rd_addr;
  logic [7:0]  i_data_count;
  logic [31:0] i_rd_data;
  logic [31:0] o_data;
  logic        o_vld, i_rdy, o_sop, o_eop, o_busy, o_overrun, o_len_err;
  logic [7:0]  o_ovr_cnt;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [7:0]  cnt_arr [4];
  logic [7:0]  fid = 8'h00;
  logic [7:0]  seq_exp = 8'h00;
  logic [33:0] exp_q [$];
  bit          cur_len_err = 1'b0;
  bit          rnd_rdy = 1'b0;
  int unsigned frame_words = 0;
  int unsigned exp_words = 0;
  bit          stall_q = 1'b0;
  logic [33:0] held_q = '0;

  always #5 clk = ~clk;

  phy_frame_reader #(
    .RD_LAT     (1),
    .FIFO_DEPTH (4),
    .HDR_TAG    (4'hA)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_frame_ready (i_frame_ready),
    .i_out_size    (i_out_size),
    .o_rd_vchn     (o_rd_vchn),
    .o_rd_addr     (o_rd_addr),
    .i_data_count  (i_data_count),
    .i_rd_data     (i_rd_data),
    .o_data        (o_data),
    .o_vld         (o_vld),
    .i_rdy         (i_rdy),
    .o_sop         (o_sop),
    .o_eop         (o_eop),
    .o_busy        (o_busy),
    .o_overrun     (o_overrun),
    .o_ovr_cnt     (o_ovr_cnt),
    .o_len_err     (o_len_err)
  );

  function automatic logic [31:0] bd(input logic [7:0] f, input logic [1:0] v, input logic [7:0] a);
    return {f, 6'd0, v, 8'h3C, a};
  endfunction

  // Capture buffer model: count is combinational, data arrives one cycle after the address.
  assign i_data_count = cnt_arr[o_rd_vchn];
  always @(posedge clk) i_rd_data <= bd(fid, o_rd_vchn, o_rd_addr);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    i_rdy = 1'b0;
    forever begin
      @(posedge clk); #1;
      i_rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) chk("hold", {o_vld, o_sop, o_eop, o_data}, {1'b1, held_q});
      if (o_vld && i_rdy) begin
        frame_words++;
        if (exp_q.size() == 0) begin
          chk("unexpected_word", {o_sop, o_eop, o_data}, 34'h0_DEAD_BEEF);
        end else begin
          chk("word", {o_sop, o_eop, o_data}, exp_q.pop_front());
          if (o_eop) chk("len_err", o_len_err, cur_len_err);
        end
      end
      stall_q = o_vld && !i_rdy;
      held_q  = {o_sop, o_eop, o_data};
    end
  end

  task automatic start_frame(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2,
                             input logic [7:0] c3, input logic [15:0] sz, input bit lerr);
    cnt_arr[0] = c0; cnt_arr[1] = c1; cnt_arr[2] = c2; cnt_arr[3] = c3;
    cur_len_err = lerr;
    frame_words = 0;
    exp_words   = 4;
    for (int v = 0; v < 4; v++) begin
      logic [7:0] c;
      c = cnt_arr[v];
      exp_words += c;
      exp_q.push_back({v == 0, (v == 3) && (c == 8'd0), 4'hA, 2'(v), 2'b00, seq_exp, 8'h00, c});
      for (int a = 0; a < int'(c); a++)
        exp_q.push_back({1'b0, (v == 3) && (a == int'(c) - 1), bd(fid, 2'(v), 8'(a))});
    end
    @(posedge clk); #1;
    i_out_size    = sz;
    i_frame_ready = 1'b1;
    @(negedge clk);
    chk("lat_n0", o_vld, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("lat_n2_sop", {o_vld, o_sop}, 2'b11);
  endtask

  task automatic finish_frame(input bit keep_ready);
    int unsigned n;
    n = 0;
    while ((exp_q.size() != 0 || o_busy) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("frame_done", n < 20000, 1'b1);
    chk("frame_words", frame_words, exp_words);
    seq_exp++;
    fid++;
    if (!keep_ready) begin
      @(posedge clk); #1;
      i_frame_ready = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0;
    i_frame_ready = 1'b0;
    i_out_size = '0;
    cnt_arr[0] = '0; cnt_arr[1] = '0; cnt_arr[2] = '0; cnt_arr[3] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {o_data, o_vld, o_sop, o_eop, o_busy, o_overrun, o_ovr_cnt, o_len_err,
                          o_rd_vchn, o_rd_addr}, '0);
    rst_n = 1'b1;

    start_frame(8'd3, 8'd0, 8'd2, 8'd1, 16'd10, 1'b0);
    finish_frame(1'b0);

    start_frame(8'd0, 8'd0, 8'd0, 8'd0, 16'd4, 1'b0);
    finish_frame(1'b0);

    rnd_rdy = 1'b1;
    start_frame(8'd255, 8'd255, 8'd255, 8'd255, 16'd1024, 1'b0);
    finish_frame(1'b0);
    rnd_rdy = 1'b0;

    start_frame(8'd4, 8'd4, 8'd4, 8'd4, 16'd20, 1'b0);
    repeat (3) @(posedge clk);
    #1 i_frame_ready = 1'b0;
    @(posedge clk); #1 i_frame_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      @(negedge clk);
      seen = o_overrun;
    end
    chk("ovr_pulse", seen, 1'b1);
    chk("ovr_cnt", o_ovr_cnt, 8'd1);
    @(negedge clk);
    chk("ovr_one_cycle", o_overrun, 1'b0);
    finish_frame(1'b1);
    repeat (10) @(posedge clk);
    #1;
    chk("ovr_frame_skipped", {o_busy, o_vld}, 2'b00);
    i_frame_ready = 1'b0;
    @(posedge clk); #1;

    start_frame(8'd1, 8'd2, 8'd3, 8'd0, 16'd11, 1'b1);
    finish_frame(1'b0);

    start_frame(8'd10, 8'd10, 8'd10, 8'd10, 16'd44, 1'b0);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {o_data, o_vld, o_sop, o_eop, o_busy, o_overrun, o_ovr_cnt,
                                o_len_err, o_rd_vchn, o_rd_addr}, '0);
    exp_q.delete();
    i_frame_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seq_exp = 8'h00;
    fid++;
    start_frame(8'd2, 8'd1, 8'd0, 8'd1, 16'd8, 1'b0);
    finish_frame(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/phy_frame_reader.md
Name: phy_frame_reader

Overview:
- Downstream consumer of the per-channel PHY capture buffer.
- Waits for a completed frame (frame_ready). Walks virtual channels 0..3. For each channel it emits one header word, then that channel's captured words read from the buffer.
- Output is a packet on a valid/ready word stream for the uplink packer.
- Total words per frame equals the buffer's reported out_size (4 headers + sum of counts).

Parameters:
- RD_LAT, 1, buffer read latency in cycles (rd_addr/rd_vchn to rd_data).
- FIFO_DEPTH, 4, output FIFO depth (power of two, >= RD_LAT+3).
- HDR_TAG, 4'hA, tag placed in header word bits [31:28].

Ports:
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- i_frame_ready  in  1  level; high = completed frame available in buffer
- i_out_size  in  16  words in frame (4 + sum of counts)
- o_rd_vchn  out  2  virtual channel select to buffer
- o_rd_addr  out  8  word address within channel
- i_data_count  in  8  word count for o_rd_vchn (combinational from buffer)
- i_rd_data  in  32  buffer read data, valid RD_LAT cycles after address
- o_data  out  32  stream word
- o_vld  out  1  stream valid
- i_rdy  in  1  stream ready
- o_sop  out  1  first word of frame
- o_eop  out  1  last word of frame
- o_busy  out  1  frame read in progress
- o_overrun  out  1  one-cycle pulse, new frame arrived while busy
- o_ovr_cnt  out  8  saturating overrun count
- o_len_err  out  1  one-cycle pulse at eop, emitted word count != latched i_out_size

Behaviour:
- Clock and reset: single clock clk; asynchronous active-low reset rst_n.
- Reset values: all outputs 0, FSM IDLE, FIFO empty, frame_seq = 0, served = 0.
- Transfer rule: a word transfers when o_vld & i_rdy. o_data/o_sop/o_eop are held stable while o_vld & ~i_rdy.
- Frame start:
  - rdy_rise = i_frame_ready & ~served.
  - served is set on start and cleared when i_frame_ready is low.
  - Start latches i_out_size into exp_len, sets vchn = 0, and enters HDR.
- FSM states:
  - IDLE -> HDR on rdy_rise.
  - HDR:
    - Waits until in-flight reads == 0 and FIFO has space.
    - Pushes header {HDR_TAG, vchn[1:0], 2'b00, frame_seq[7:0], 8'h00, i_data_count}.
    - Latches cnt = i_data_count and addr = 0.
    - Next state: DATA if cnt != 0, else NEXT.
  - DATA:
    - Issues one read per cycle while (fifo_used + inflight) < FIFO_DEPTH.
    - Returned i_rd_data is pushed RD_LAT cycles later.
    - After issuing addr = cnt-1 -> NEXT.
  - NEXT: vchn == 3 -> DRAIN; else vchn += 1 -> HDR.
  - DRAIN:
    - Waits until inflight == 0 and FIFO empty.
    - Then frame_seq += 1 (8-bit wrap) -> IDLE.
- Word ordering: in-flight data must be pushed before the next header. HDR waits for inflight == 0 to guarantee this.
- Throughput: with i_rdy held 1, one word per cycle during DATA. At most 1 bubble cycle at each HDR.
- Latency: rdy_rise at cycle N -> first o_vld (header, o_sop = 1) at cycle N+2.
- o_sop/o_eop:
  - o_sop is tagged on the first header pushed.
  - o_eop is tagged on the last word pushed: last data word of vchn 3, or the vchn 3 header if its count is 0.
- o_busy = (state != IDLE) | FIFO not empty.
- Length check: emitted-word counter (16-bit) is compared with exp_len at the eop transfer; a mismatch pulses o_len_err.
- Overrun:
  - Condition: i_frame_ready rising (0->1) while o_busy.
  - Response: pulse o_overrun and increment o_ovr_cnt, saturating at 255.
  - The current frame completes normally; served is set, so the new frame is skipped.
- Simultaneous events: the pop and push of the same cycle both occur; FIFO count is unchanged.
- i_frame_ready falling mid-frame: ignored; the read continues.
- Reset mid-operation: immediate return to reset values. The stream drops mid-packet without eop; the consumer discards it.

Decomposition:
- Shared package phy_pkg holds:
  - NUM_VCHN = 4
  - HDR_TAG default
  - header field offsets/widths
  - FSM state encoding (IDLE, HDR, DATA, NEXT, DRAIN)
- One sub-module, out_fifo_sync: synchronous FIFO, 34 bits wide (data + sop + eop), depth FIFO_DEPTH, show-ahead output, with used-count.

Test Plan:
- Counts {3,0,2,1}, out_size 10, i_rdy = 1:
  - Exactly 10 words, in order H0, D0..D2, H1, H2, D0, D1, H3, D0.
  - o_sop on H0, o_eop on last word, no o_len_err.
- All counts 0, out_size 4:
  - 4 header words, count field 0.
  - o_eop on H3.
  - frame_seq increments in the next frame's headers.
- Counts {255,255,255,255}, out_size 1024, i_rdy random 50%:
  - 1024 words, data matches buffer model, no loss or duplication.
  - o_data held stable during stalls.
- Second frame_ready rise while busy: o_overrun pulse, o_ovr_cnt = 1; the current frame still ends with eop.
- out_size 11 with counts summing to 6: o_len_err pulses on the eop transfer.
- Reset asserted during DATA: all outputs 0 asynchronously; after release the next frame_ready is served cleanly with frame_seq = 0.
